// File: rtl/fp_align_stage_if.sv
// Operand/result bundle for the FP alignment stage: upstream valid/ready with
// two operands, downstream valid/ready with the aligned pair.
interface fp_align_stage_if #(
    parameter int ExponentSize = 8,
    parameter int MantissaSize = 23,
    parameter int GuardBits    = 3
);
    localparam int M = MantissaSize + 1;
    localparam int W = M + GuardBits;

    logic                    in_valid;
    logic                    in_ready;
    logic [ExponentSize-1:0] exponent1;
    logic [ExponentSize-1:0] exponent2;
    logic [M-1:0]            mantissa1;
    logic [M-1:0]            mantissa2;

    logic                    out_valid;
    logic                    out_ready;
    logic [ExponentSize-1:0] big_exponent;
    logic [W-1:0]            big_mantissa;
    logic [W-1:0]            aligned_mantissa;
    logic [ExponentSize-1:0] difference;
    logic                    swap;
    logic                    zero_flag;

    // master: the environment feeding operands and consuming results
    modport master (
        output in_valid, exponent1, exponent2, mantissa1, mantissa2, out_ready,
        input  in_ready, out_valid, big_exponent, big_mantissa, aligned_mantissa,
               difference, swap, zero_flag
    );

    // slave: the alignment stage itself
    modport slave (
        input  in_valid, exponent1, exponent2, mantissa1, mantissa2, out_ready,
        output in_ready, out_valid, big_exponent, big_mantissa, aligned_mantissa,
               difference, swap, zero_flag
    );
endinterface

// File: rtl/fp_align_stage.sv
// Two-stage FP add/sub alignment: S1 orders the operands by magnitude, S2
// right-shifts the smaller mantissa with guard bits and a sticky LSB.
module fp_align_stage #(
    parameter int ExponentSize = 8,
    parameter int MantissaSize = 23,
    parameter int GuardBits    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fp_align_stage_if.slave  bus
);
    localparam int M = MantissaSize + 1;
    localparam int W = M + GuardBits;
    localparam logic [31:0] WidthU = 32'(W);

    logic                    s1_valid_q;
    logic [ExponentSize-1:0] s1_big_exp_q, s1_diff_q;
    logic [M-1:0]            s1_big_man_q, s1_small_man_q;
    logic                    s1_swap_q, s1_zero_q;

    logic                    out_valid_q;
    logic [ExponentSize-1:0] big_exp_q, diff_q;
    logic [W-1:0]            big_man_q, aligned_q;
    logic                    swap_q, zero_q;

    logic                    s1_load, s2_load;
    logic                    swap_d;
    logic [ExponentSize-1:0] big_exp_d, diff_d;
    logic [M-1:0]            big_man_d, small_man_d;

    assign s2_load      = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !rst_i && (!s1_valid_q || s2_load);
    assign s1_load      = bus.in_valid && bus.in_ready;

    // Fully equal operands keep their original order.
    assign swap_d = (bus.exponent2 > bus.exponent1) ||
                    ((bus.exponent2 == bus.exponent1) && (bus.mantissa2 > bus.mantissa1));

    always_comb begin
        big_exp_d   = bus.exponent1;
        big_man_d   = bus.mantissa1;
        small_man_d = bus.mantissa2;
        diff_d      = bus.exponent1 - bus.exponent2;
        if (swap_d) begin
            big_exp_d   = bus.exponent2;
            big_man_d   = bus.mantissa2;
            small_man_d = bus.mantissa1;
            diff_d      = bus.exponent2 - bus.exponent1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q     <= 1'b0;
            s1_big_exp_q   <= '0;
            s1_diff_q      <= '0;
            s1_big_man_q   <= '0;
            s1_small_man_q <= '0;
            s1_swap_q      <= 1'b0;
            s1_zero_q      <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q     <= 1'b1;
                s1_big_exp_q   <= big_exp_d;
                s1_diff_q      <= diff_d;
                s1_big_man_q   <= big_man_d;
                s1_small_man_q <= small_man_d;
                s1_swap_q      <= swap_d;
                s1_zero_q      <= (bus.exponent1 == bus.exponent2);
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    logic [W-1:0] ext_small;
    logic [W-1:0] lost_bits;
    logic         saturate;
    logic [W-1:0] aligned_d;

    assign ext_small = {s1_small_man_q, {GuardBits{1'b0}}};
    assign saturate  = 32'(s1_diff_q) >= WidthU;

    // Bit gi falls off the right end whenever the shift distance exceeds gi.
    for (genvar gi = 0; gi < W; gi++) begin : g_lost
        assign lost_bits[gi] = ext_small[gi] & (32'(s1_diff_q) > 32'(gi));
    end

    assign aligned_d = saturate ? {{(W-1){1'b0}}, |ext_small}
                                : ((ext_small >> s1_diff_q) | {{(W-1){1'b0}}, |lost_bits});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            big_exp_q   <= '0;
            diff_q      <= '0;
            big_man_q   <= '0;
            aligned_q   <= '0;
            swap_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= 1'b1;
            big_exp_q   <= s1_big_exp_q;
            diff_q      <= s1_diff_q;
            big_man_q   <= {s1_big_man_q, {GuardBits{1'b0}}};
            aligned_q   <= aligned_d;
            swap_q      <= s1_swap_q;
            zero_q      <= s1_zero_q;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid        = out_valid_q;
    assign bus.big_exponent     = big_exp_q;
    assign bus.big_mantissa     = big_man_q;
    assign bus.aligned_mantissa = aligned_q;
    assign bus.difference       = diff_q;
    assign bus.swap             = swap_q;
    assign bus.zero_flag        = zero_q;
endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: directed cases, backpressure, reset mid-stream and
// randomized traffic against an arithmetic reference model with a scoreboard.
module tb_fp_align_stage;
    localparam int ES = 8;
    localparam int MS = 23;
    localparam int GB = 3;
    localparam int M  = MS + 1;
    localparam int W  = M + GB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_align_stage_if #(.ExponentSize(ES), .MantissaSize(MS), .GuardBits(GB)) bus ();

    fp_align_stage #(.ExponentSize(ES), .MantissaSize(MS), .GuardBits(GB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [ES-1:0] bexp;
        logic [W-1:0]  bman;
        logic [W-1:0]  aman;
        logic [ES-1:0] diff;
        logic          swap;
        logic          zero;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    logic last_accept = 1'b0;
    logic prev_stall = 1'b0;
    txn_t prev_out;

    function automatic txn_t mk(int unsigned bexp, longint unsigned bman, longint unsigned aman,
                                int unsigned diff, logic swap, logic zero);
        txn_t t;
        t.bexp = ES'(bexp);
        t.bman = W'(bman);
        t.aman = W'(aman);
        t.diff = ES'(diff);
        t.swap = swap;
        t.zero = zero;
        return t;
    endfunction

    // Magnitude ordering and sticky alignment expressed as plain integer arithmetic.
    function automatic txn_t model(int unsigned e1, int unsigned e2, int unsigned m1, int unsigned m2);
        txn_t            t;
        int unsigned     be, d;
        longint unsigned bm, sm, ext, p, q;
        logic            sw;
        sw = (e2 > e1) || (e2 == e1 && m2 > m1);
        if (sw) begin be = e2; d = e2 - e1; bm = m2; sm = m1; end
        else    begin be = e1; d = e1 - e2; bm = m1; sm = m2; end
        ext = sm * (64'd1 << GB);
        if (d >= W) begin
            q = (ext != 0) ? 64'd1 : 64'd0;
        end else begin
            p = 64'd1 << d;
            q = ext / p;
            if (ext % p != 0) q = q | 64'd1;
        end
        t = mk(be, bm * (64'd1 << GB), q, d, sw, e1 == e2);
        return t;
    endfunction

    function automatic txn_t get_out();
        return mk(32'(bus.big_exponent), 64'(bus.big_mantissa), 64'(bus.aligned_mantissa),
                  32'(bus.difference), bus.swap, bus.zero_flag);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_txn(input string tag, input txn_t o, input txn_t e);
        chk({tag, ".bexp"}, 64'(o.bexp), 64'(e.bexp));
        chk({tag, ".bman"}, 64'(o.bman), 64'(e.bman));
        chk({tag, ".aman"}, 64'(o.aman), 64'(e.aman));
        chk({tag, ".diff"}, 64'(o.diff), 64'(e.diff));
        chk({tag, ".swap"}, 64'(o.swap), 64'(e.swap));
        chk({tag, ".zero"}, 64'(o.zero), 64'(e.zero));
    endtask

    task automatic drive(input int unsigned e1, input int unsigned e2,
                         input int unsigned m1, input int unsigned m2, input logic v);
        bus.exponent1 = ES'(e1);
        bus.exponent2 = ES'(e2);
        bus.mantissa1 = M'(m1);
        bus.mantissa2 = M'(m2);
        bus.in_valid  = v;
    endtask

    // Called just after an edge with inputs set; resolves both handshakes for the coming edge.
    task automatic cycle();
        txn_t e;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 64'(bus.out_valid), 64'(1));
            chk_txn("stall_hold", get_out(), prev_out);
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_txn("scoreboard", get_out(), e);
                popped++;
            end
        end
        last_accept = bus.in_valid && bus.in_ready;
        if (last_accept)
            exp_q.push_back(model(32'(bus.exponent1), 32'(bus.exponent2),
                                  32'(bus.mantissa1), 32'(bus.mantissa2)));
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = get_out();
        @(posedge clk);
        #1;
    endtask

    task automatic run_directed(input string tag, input int unsigned e1, input int unsigned e2,
                                input int unsigned m1, input int unsigned m2, input txn_t want);
        bus.out_ready = 1'b1;
        drive(e1, e2, m1, m2, 1'b1);
        cycle();
        chk({tag, ".accepted"}, 64'(last_accept), 64'(1));
        bus.in_valid = 1'b0;
        chk({tag, ".lat1_valid"}, 64'(bus.out_valid), 64'(0));
        cycle();
        chk({tag, ".lat2_valid"}, 64'(bus.out_valid), 64'(1));
        chk_txn(tag, get_out(), want);
        cycle();
        $display("directed %s: e1=%0h e2=%0h m1=%0h m2=%0h -> aligned=%0h", tag, e1, e2, m1, m2, want.aman);
    endtask

    int unsigned bp_e1[3] = '{32'h85, 32'h40, 32'h7F};
    int unsigned bp_e2[3] = '{32'h82, 32'h44, 32'h7F};
    int unsigned bp_m1[3] = '{32'h800000, 32'hABCDEF, 32'h900000};
    int unsigned bp_m2[3] = '{32'hC00000, 32'h812345, 32'hA00000};

    initial begin
        int   idx;
        int   budget;
        int   base;
        txn_t snap;
        txn_t zero_t;
        int unsigned re1, re2, rm1, rm2;

        zero_t = mk(0, 0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk_txn("rst_data", get_out(), zero_t);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        run_directed("basic", 32'h85, 32'h82, 32'h800000, 32'hC00000,
                     mk(32'h85, 64'h4000000, 64'h0C00000, 3, 1'b0, 1'b0));
        run_directed("sticky", 32'h90, 32'h8B, 32'h800000, 32'h800001,
                     mk(32'h90, 64'h4000000, 64'h200001, 5, 1'b0, 1'b0));
        run_directed("sat", 32'h10, 32'h90, 32'h800000, 32'hA00000,
                     mk(32'h90, 64'h5000000, 64'h1, 32'h80, 1'b1, 1'b0));
        run_directed("sat_zero", 32'h10, 32'h90, 32'h0, 32'hA00000,
                     mk(32'h90, 64'h5000000, 64'h0, 32'h80, 1'b1, 1'b0));
        run_directed("tie", 32'h7F, 32'h7F, 32'h900000, 32'hA00000,
                     mk(32'h7F, 64'h5000000, 64'h4800000, 0, 1'b1, 1'b1));
        run_directed("equal", 32'h7F, 32'h7F, 32'h900000, 32'h900000,
                     mk(32'h7F, 64'h4800000, 64'h4800000, 0, 1'b0, 1'b1));
        run_directed("diff25", 32'h40, 32'h27, 32'h800000, 32'h800000,
                     mk(32'h40, 64'h4000000, 64'h2, 25, 1'b0, 1'b0));
        run_directed("diff26", 32'h40, 32'h26, 32'h800000, 32'h800001,
                     mk(32'h40, 64'h4000000, 64'h1, 26, 1'b0, 1'b0));
        run_directed("diff27", 32'h40, 32'h25, 32'h800000, 32'h800000,
                     mk(32'h40, 64'h4000000, 64'h1, 27, 1'b0, 1'b0));

        // Backpressure: three offers into a stalled pipe
        bus.out_ready = 1'b0;
        idx  = 0;
        base = popped;
        for (int c = 0; c < 4; c++) begin
            if (idx < 3) drive(bp_e1[idx], bp_e2[idx], bp_m1[idx], bp_m2[idx], 1'b1);
            cycle();
            if (last_accept) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'(2));
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        chk_txn("bp_head", get_out(), model(bp_e1[0], bp_e2[0], bp_m1[0], bp_m2[0]));
        snap = get_out();
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk_txn("bp_stable", get_out(), snap);
            chk("bp_stall_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        budget = 20;
        while ((idx < 3 || exp_q.size() != 0) && budget > 0) begin
            if (idx < 3) drive(bp_e1[idx], bp_e2[idx], bp_m1[idx], bp_m2[idx], 1'b1);
            else bus.in_valid = 1'b0;
            cycle();
            if (last_accept) idx++;
            budget--;
        end
        chk("bp_drained", 64'(budget > 0), 64'(1));
        chk("bp_popped", 64'(popped - base), 64'(3));
        $display("backpressure: accepted %0d, emerged %0d", idx, popped - base);

        // Reset with two transactions in flight
        bus.out_ready = 1'b0;
        idx    = 0;
        budget = 10;
        while (idx < 2 && budget > 0) begin
            drive(32'h50 + idx, 32'h48, 32'hF00000, 32'h812345, 1'b1);
            cycle();
            if (last_accept) idx++;
            budget--;
        end
        chk("rs_filled", 64'(idx), 64'(2));
        rst = 1'b1;
        drive(32'h33, 32'h22, 32'h811111, 32'h822222, 1'b1);
        #1;
        chk("rs_in_ready_low", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rs_out_valid", 64'(bus.out_valid), 64'(0));
        chk_txn("rs_data", get_out(), zero_t);
        chk("rs_in_ready", 64'(bus.in_ready), 64'(1));
        exp_q.delete();
        prev_stall = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("rs_no_ghost", 64'(bus.out_valid), 64'(0));
        end
        $display("reset mid-stream: in-flight discarded");
        run_directed("post_rst", 32'h81, 32'h80, 32'hC00000, 32'hFFFFFF,
                     model(32'h81, 32'h80, 32'hC00000, 32'hFFFFFF));

        // Randomized traffic
        base = popped;
        for (int c = 0; c < 400; c++) begin
            re1 = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0:       re2 = re1;
                1:       re2 = (re1 + $urandom_range(0, 30)) % 256;
                default: re2 = $urandom_range(0, 255);
            endcase
            rm1 = 32'h800000 | ($urandom & 32'h7FFFFF);
            case ($urandom_range(0, 5))
                0:       rm2 = rm1;
                1:       rm2 = 0;
                default: rm2 = 32'h800000 | ($urandom & 32'h7FFFFF);
            endcase
            drive(re1, re2, rm1, rm2, $urandom_range(0, 9) < 7);
            bus.out_ready = $urandom_range(0, 9) < 6;
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        $display("random: %0d transactions checked", popped - base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
